mesm6_panel_display: RTL
========================

# mesm6_panel_display

Front-panel output driver for MESM-6: takes hex register values from the core and time-multiplexes them onto a common-anode seven-segment/lamp array. It is the output-side counterpart of the panel switch debouncer, using the same slow scan tick for digit slots. A load handshake with a one-deep pending buffer swaps new data in only at frame boundaries, so a frame never shows half-old, half-new digits. It adds ghost-suppression blanking and 16-level PWM brightness.

## Interface
- DIGITS, 8: number of multiplexed digits, 2..16.
- PRESCALE, 65000: clk cycles per digit slot; ≥ BLANK_CYCLES+16.
- BLANK_CYCLES, 64: cycles at slot start with all digits off.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  new frame offered.
- load_ready  out  1  pending buffer empty; transfer when valid&&ready.
- load_data  in  4*DIGITS  hex nibbles; digit i = load_data[4i+3:4i], digit 0 scanned first.
- load_dp  in  DIGITS  decimal-point per digit, 1 = lit.
- brightness  in  4  duty level 0..15.
- seg_out  out  8  active-low segments, [0]=a … [6]=g, [7]=dp.
- dig_out  out  DIGITS  active-low digit enables, one-hot-low or all-high.

## Operation
- Registers: active buffer (data, dp), pending buffer plus pending_valid, digit index idx, slot counter slot_cnt (0..PRESCALE-1), 4-bit free-running pwm_cnt, latched brightness bri_q.
- load_ready = !pending_valid. On a transfer, load_data/load_dp go to pending and pending_valid is set.
- slot_cnt increments every clk and wraps at PRESCALE-1. On wrap, idx advances and wraps at DIGITS-1.
- Frame boundary is the wrap cycle with idx==DIGITS-1. On that cycle, if pending_valid: pending is copied to active and pending_valid is cleared.
- A load accepted on the boundary cycle itself, with pending empty before it, lands in pending and is applied at the following boundary.
- bri_q samples brightness on each slot wrap; mid-slot changes are ignored.
- Per-slot FSM with states BLANK, ON, driven by slot_cnt:
  - BLANK while slot_cnt < BLANK_CYCLES: dig_out all 1, seg_out all 1.
  - ON otherwise. dig_out[idx]=0 when pwm_cnt < bri_q, else all 1. seg_out = ~{dp[idx], hex7(data[idx])}.
  - bri_q=0 means never lit; bri_q=15 means lit 15/16 of ON cycles.
- hex7 encoding (gfedcba, active-high before inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Outputs are registered; no combinational path from inputs to seg_out/dig_out.

## Timing
- Reset values: seg_out=8'hFF, dig_out all 1, load_ready=1, active buffer 0, pending empty, idx=0, slot_cnt=0, pwm_cnt=0, bri_q=0.
- Reset assertion forces all of the above immediately (asynchronous). Reset in the middle of a frame discards pending and active data.
- After reset, the display stays dark until the first frame boundary with pending_valid, since bri_q also resets to 0.
- Outputs lag internal state by one register stage. First lit cycle of a slot is slot_cnt==BLANK_CYCLES+1 relative to the slot wrap.
- Load latency: a transfer is visible from the first slot of digit 0 after the next frame boundary, at most DIGITS*PRESCALE+1 cycles.
- load_ready falls the cycle after a transfer. It rises the cycle after the boundary that consumes pending.
- Frame period = DIGITS*PRESCALE cycles exactly. Slot period is jitter-free.

## Structure
- The hex7 segment table and the segment bit-position constants go in mesm6_defines.sv for reuse by other panel blocks.
- One sub-module: mesm6_hex7seg, a combinational nibble-to-7-bit decoder.
- Everything else, including counters, the FSM and the buffers, lives in mesm6_panel_display.

## Test plan
All scenarios use DIGITS=4, PRESCALE=20, BLANK_CYCLES=2.
- Reset: hold rst_n=0 mid-slot → seg_out=FF, dig_out=F and load_ready=1 asynchronously. No digit lights in the first frame after release.
- Single load: load_data=16'h3210, dp=4'b0001, brightness=15 → from the next boundary, digit 0 shows seg_out=~8'hBF, digit 1 shows ~8'h06, digit 3 shows ~8'h4F. Each digit is dark for 2 cycles, then lit except when pwm_cnt==15.
- Backpressure: load A, then hold a second load B valid → load_ready=0 until the boundary. A is displayed for a full frame, then B is accepted and shown one frame later. No digit shows a mix of A and B within a frame.
- Boundary collision: pending empty, transfer on the exact boundary cycle → the old frame repeats once, and the new data appears at the following boundary.
- Brightness: bri=0 → dig_out never 0. bri=8 → exactly 8 of every 16 consecutive ON cycles lit. Changing brightness mid-slot takes effect at the next slot only.
- Scan order and period: dig_out low pulses appear in order 0,1,2,3. Each pulse starts 20 cycles after the previous one, and the frame repeats every 80 cycles.

Source files
------------

// File: rtl/mesm6_defines.sv
// Shared front-panel definitions for the MESM-6 panel blocks.
// Holds the segment bit positions, the hex-to-seven-segment table
// (gfedcba, active-high) and the per-slot scan state type.
// No ports: package only.
package mesm6_defines;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

  // Entry n is the glyph for nibble n; listed F down to 0 because the
  // concatenation fills the packed array from the top index.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } slot_state_e;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return HEX7_TABLE[nib];
  endfunction

endpackage

// File: rtl/mesm6_hex7seg.sv
// Combinational nibble to seven-segment decoder.
// Ports:
//   nibble  in  4  hex value
//   seg     out 7  segments gfedcba, active-high
module mesm6_hex7seg
  import mesm6_defines::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex7(nibble);

endmodule

// File: rtl/mesm6_panel_display.sv
// MESM-6 front-panel display driver. Time-multiplexes DIGITS hex digits
// onto a common-anode seven-segment array, with blanking at the start of
// every digit slot and 16-level PWM brightness. New frames are offered
// through a valid/ready handshake into a one-deep pending buffer and only
// become visible at a frame boundary.
//
// state  | meaning
// -------+---------------------------------------------------------
// BLANK  | first BLANK_CYCLES cycles of a slot, every digit off
// ON     | rest of the slot, current digit driven under PWM gating
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   load_valid  in   new frame offered
//   load_ready  out  pending buffer empty
//   load_data   in   4*DIGITS hex nibbles, digit 0 in the low nibble
//   load_dp     in   DIGITS decimal points, 1 = lit
//   brightness  in   duty level 0..15, sampled at slot wrap
//   seg_out     out  active-low segments, [7] = dp
//   dig_out     out  active-low digit enables
module mesm6_panel_display
  import mesm6_defines::*;
#(
  parameter int DIGITS       = 8,
  parameter int PRESCALE     = 65000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [3:0]            brightness,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_out
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SLOT_W = $clog2(PRESCALE);

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE_HOT    = DIGITS'(1);

  logic [SLOT_W-1:0]   slot_cnt;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          pwm_cnt;
  logic [3:0]          bri_q;
  logic [4*DIGITS-1:0] act_data;
  logic [DIGITS-1:0]   act_dp;
  logic [4*DIGITS-1:0] pend_data;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_valid;
  // Set once the first real frame reaches the active buffer; keeps the
  // panel dark until then even though bri_q starts tracking at slot wrap.
  logic                frame_valid;
  slot_state_e         state;

  logic                slot_wrap;
  logic                frame_wrap;
  logic [3:0]          cur_nib;
  logic [6:0]          cur_seg7;
  logic [7:0]          seg_on;

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);
  assign load_ready = !pend_valid;

  assign cur_nib = act_data[{idx, 2'b00} +: 4];

  mesm6_hex7seg u_hex7seg (
    .nibble (cur_nib),
    .seg    (cur_seg7)
  );

  always_comb begin
    seg_on                = '0;
    seg_on[SEG_G:SEG_A]   = cur_seg7;
    seg_on[SEG_DP]        = act_dp[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      idx         <= '0;
      pwm_cnt     <= '0;
      bri_q       <= '0;
      act_data    <= '0;
      act_dp      <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;

      if (slot_wrap) begin
        slot_cnt <= '0;
        bri_q    <= brightness;
        idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end

      // A full pending buffer blocks new loads, so swap and accept can
      // never both happen on one cycle; a load on the boundary with an
      // empty buffer waits for the next boundary.
      if (frame_wrap && pend_valid) begin
        act_data    <= pend_data;
        act_dp      <= pend_dp;
        pend_valid  <= 1'b0;
        frame_valid <= 1'b1;
      end else if (load_valid && !pend_valid) begin
        pend_data  <= load_data;
        pend_dp    <= load_dp;
        pend_valid <= 1'b1;
      end
    end
  end

  // state tracks the phase of the current slot_cnt; outputs are a
  // registered image of that phase, hence the one-cycle output lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_BLANK;
      seg_out <= SEG_ALL_OFF;
      dig_out <= '1;
    end else begin
      case (state)
        ST_BLANK: begin
          seg_out <= SEG_ALL_OFF;
          dig_out <= '1;
          if (slot_cnt == BLANK_LAST) begin
            state <= ST_ON;
          end
        end
        ST_ON: begin
          seg_out <= ~seg_on;
          dig_out <= (frame_valid && (pwm_cnt < bri_q)) ? ~(ONE_HOT << idx) : '1;
          if (slot_wrap) begin
            state <= ST_BLANK;
          end
        end
        default: begin
          state   <= ST_BLANK;
          seg_out <= SEG_ALL_OFF;
          dig_out <= '1;
        end
      endcase
    end
  end

endmodule
